// File: rtl/sha3_pkg.sv
// Shared SHA-3 types and constants: lane type, state size, rate presets and
// the loader FSM encoding.
package sha3_pkg;

  typedef logic [63:0] lane_t;

  localparam int NUM_LANES = 25;

  localparam int RATE_224 = 18;
  localparam int RATE_256 = 17;
  localparam int RATE_384 = 13;
  localparam int RATE_512 = 9;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } loader_state_t;

endpackage

// File: rtl/sha3_state_loader.sv
// Collects RATE_LANES 64-bit lanes into a fill buffer, then on downstream
// acceptance copies them into the output register as a 5x5 state with a strobe.
module sha3_state_loader
  import sha3_pkg::*;
#(
  parameter int RATE_LANES = RATE_256
) (
  input  logic        clk,
  input  logic        rst,
  input  lane_t       lane_in,
  input  logic        lane_valid,
  output logic        lane_ready,
  input  logic        down_ready,
  output lane_t [0:4] osa,
  output lane_t [0:4] osb,
  output lane_t [0:4] osc,
  output lane_t [0:4] osd,
  output lane_t [0:4] ose,
  output logic        sample,
  output logic [4:0]  fill_count
);

  if (RATE_LANES < 1 || RATE_LANES > NUM_LANES) begin : g_bad_rate
    $error("sha3_state_loader: RATE_LANES must be within 1..25");
  end

  localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

  loader_state_t state_q, state_d;
  lane_t         fill_q [NUM_LANES];
  lane_t         out_q  [NUM_LANES];
  logic          accept, last_lane, dispatch;

  // Ready depends only on state and reset so upstream sees no comb loop.
  assign lane_ready = (state_q == FILL) && !rst;
  assign accept     = lane_valid && lane_ready;
  assign last_lane  = accept && (fill_count == LAST_IDX);
  assign dispatch   = (state_q == HOLD) && down_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (last_lane) state_d = HOLD;
      HOLD:    if (down_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Capacity lanes are never written, so they stay zero in both buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        fill_q[k] <= '0;
        out_q[k]  <= '0;
      end
      fill_count <= '0;
      sample     <= 1'b0;
    end else begin
      sample <= dispatch;
      if (dispatch) begin
        fill_count <= '0;
        for (int k = 0; k < NUM_LANES; k++) begin
          out_q[k]  <= (k < RATE_LANES) ? fill_q[k] : '0;
          fill_q[k] <= '0;
        end
      end else if (accept) begin
        fill_count <= fill_count + 5'd1;
        for (int k = 0; k < NUM_LANES; k++)
          if (k < RATE_LANES && fill_count == 5'(k)) fill_q[k] <= lane_in;
      end
    end
  end

  for (genvar x = 0; x < 5; x++) begin : g_row
    assign osa[x] = out_q[x];
    assign osb[x] = out_q[5 + x];
    assign osc[x] = out_q[10 + x];
    assign osd[x] = out_q[15 + x];
    assign ose[x] = out_q[20 + x];
  end

endmodule

// File: tb/tb_sha3_state_loader.sv
// Bench for sha3_state_loader: three instances (rates 17, 25, 9) driven by
// directed and randomized blocks, checked against a lane-queue reference model.
module tb_sha3_state_loader;
  import sha3_pkg::*;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [ND];
  lane_t       lane_in    [ND];
  logic        lane_valid [ND];
  logic        lane_ready [ND];
  logic        down_ready [ND];
  logic        sample     [ND];
  logic [4:0]  fill_count [ND];
  lane_t [0:4] osa [ND];
  lane_t [0:4] osb [ND];
  lane_t [0:4] osc [ND];
  lane_t [0:4] osd [ND];
  lane_t [0:4] ose [ND];

  sha3_state_loader #(.RATE_LANES(17)) u_r17 (
    .clk(clk), .rst(rst[0]), .lane_in(lane_in[0]), .lane_valid(lane_valid[0]),
    .lane_ready(lane_ready[0]), .down_ready(down_ready[0]),
    .osa(osa[0]), .osb(osb[0]), .osc(osc[0]), .osd(osd[0]), .ose(ose[0]),
    .sample(sample[0]), .fill_count(fill_count[0]));

  sha3_state_loader #(.RATE_LANES(25)) u_r25 (
    .clk(clk), .rst(rst[1]), .lane_in(lane_in[1]), .lane_valid(lane_valid[1]),
    .lane_ready(lane_ready[1]), .down_ready(down_ready[1]),
    .osa(osa[1]), .osb(osb[1]), .osc(osc[1]), .osd(osd[1]), .ose(ose[1]),
    .sample(sample[1]), .fill_count(fill_count[1]));

  sha3_state_loader #(.RATE_LANES(9)) u_r9 (
    .clk(clk), .rst(rst[2]), .lane_in(lane_in[2]), .lane_valid(lane_valid[2]),
    .lane_ready(lane_ready[2]), .down_ready(down_ready[2]),
    .osa(osa[2]), .osb(osb[2]), .osc(osc[2]), .osd(osd[2]), .ose(ose[2]),
    .sample(sample[2]), .fill_count(fill_count[2]));

  // Reference model: accepted lanes of the current block, and expected state.
  lane_t blk[$];
  lane_t exp_os [ND][NUM_LANES];
  int    vectors = 0;
  int    errs    = 0;

  function automatic int rate_of(int d);
    case (d)
      0:       return 17;
      1:       return 25;
      default: return 9;
    endcase
  endfunction

  function automatic lane_t got(int d, int k);
    case (k / 5)
      0:       return osa[d][k % 5];
      1:       return osb[d][k % 5];
      2:       return osc[d][k % 5];
      3:       return osd[d][k % 5];
      default: return ose[d][k % 5];
    endcase
  endfunction

  function automatic lane_t rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_os(int d, string tag);
    for (int k = 0; k < NUM_LANES; k++)
      chk($sformatf("%s d%0d lane%0d", tag, d, k), got(d, k), exp_os[d][k]);
  endtask

  task automatic model_dispatch(int d);
    for (int k = 0; k < NUM_LANES; k++)
      exp_os[d][k] = (k < rate_of(d)) ? blk[k] : 64'd0;
    blk.delete();
  endtask

  task automatic do_reset(int d, int cycles);
    rst[d] = 1'b1;
    blk.delete();
    for (int k = 0; k < NUM_LANES; k++) exp_os[d][k] = '0;
    for (int c = 0; c < cycles; c++) begin
      lane_valid[d] = 1'($urandom);
      down_ready[d] = 1'($urandom);
      lane_in[d]    = rnd64();
      step();
      chk("rst lane_ready", lane_ready[d], 0);
      chk("rst sample", sample[d], 0);
      chk("rst fill_count", fill_count[d], 0);
    end
    chk_os(d, "rst os");
    rst[d]        = 1'b0;
    lane_valid[d] = 1'b0;
    down_ready[d] = 1'b0;
    step();
    chk("post-rst lane_ready", lane_ready[d], 1);
    chk("post-rst fill_count", fill_count[d], 0);
    chk("post-rst sample", sample[d], 0);
  endtask

  // Streams one block; gap selects the 1,0,0 valid pattern, stall holds
  // down_ready low for that many cycles once the buffer is full.
  task automatic run_block(int d, bit gap, int stall, lane_t base, bit rnd);
    lane_t vals [NUM_LANES];
    int    n   = rate_of(d);
    int    k   = 0;
    int    cyc = 0;
    bit    v;
    for (int i = 0; i < NUM_LANES; i++) vals[i] = rnd ? rnd64() : base + lane_t'(i);
    down_ready[d] = (stall == 0);
    while (k < n) begin
      v             = gap ? (cyc % 3 == 0) : 1'b1;
      lane_valid[d] = v;
      lane_in[d]    = v ? vals[k] : rnd64();
      chk("fill lane_ready", lane_ready[d], 1);
      step();
      cyc++;
      if (v) begin
        blk.push_back(vals[k]);
        k++;
      end
      chk("fill fill_count", fill_count[d], blk.size());
      chk("fill sample", sample[d], 0);
    end
    // Buffer full: extra valid lanes must be ignored while holding.
    lane_valid[d] = 1'b1;
    lane_in[d]    = rnd64();
    chk_os(d, "hold keeps prev");
    for (int s = 0; s < stall; s++) begin
      chk("stall lane_ready", lane_ready[d], 0);
      step();
      chk("stall sample", sample[d], 0);
      chk("stall fill_count", fill_count[d], n);
    end
    if (stall > 0) chk_os(d, "stall keeps prev");
    down_ready[d] = 1'b1;
    chk("hold lane_ready", lane_ready[d], 0);
    step();
    model_dispatch(d);
    chk("dispatch sample", sample[d], 1);
    chk("dispatch lane_ready", lane_ready[d], 1);
    chk("dispatch fill_count", fill_count[d], 0);
    chk_os(d, "dispatch os");
    lane_valid[d] = 1'b0;
  endtask

  initial begin
    int dead;
    for (int d = 0; d < ND; d++) begin
      rst[d]        = 1'b1;
      lane_in[d]    = '0;
      lane_valid[d] = 1'b0;
      down_ready[d] = 1'b0;
      for (int k = 0; k < NUM_LANES; k++) exp_os[d][k] = '0;
    end
    step();
    for (int d = 0; d < ND; d++) do_reset(d, 3);

    // Back-to-back, then an idle cycle to see the strobe drop.
    run_block(0, 1'b0, 0, 64'd1, 1'b0);
    chk("b2b osd[1]", osd[0][1], 64'd17);
    chk("b2b osd[2]", osd[0][2], 64'd0);
    step();
    chk("strobe one cycle", sample[0], 0);
    chk_os(0, "idle holds");

    // Backpressure, then a second block streamed with no gap.
    run_block(0, 1'b0, 10, 64'd1, 1'b0);
    run_block(0, 1'b0, 0, 64'h1000, 1'b0);

    // Valid gaps.
    run_block(0, 1'b1, 0, 64'd1, 1'b0);
    chk("gap osa[0]", osa[0][0], 64'd1);

    // Reset mid-fill discards the partial block.
    for (int i = 0; i < 8; i++) begin
      lane_valid[0] = 1'b1;
      lane_in[0]    = 64'hDEAD;
      step();
    end
    chk("midfill fill_count", fill_count[0], 8);
    do_reset(0, 2);
    run_block(0, 1'b0, 0, 64'h100, 1'b0);
    chk("midfill lane0", osa[0][0], 64'h100);
    dead = 0;
    for (int k = 0; k < NUM_LANES; k++) if (got(0, k) == 64'hDEAD) dead++;
    chk("midfill no DEAD", dead, 0);

    // Full-width and short rates.
    run_block(1, 1'b0, 0, 64'd1, 1'b0);
    chk("r25 ose[4]", ose[1][4], 64'd25);
    run_block(2, 1'b0, 0, 64'd1, 1'b0);
    chk("r9 osb[3]", osb[2][3], 64'd9);
    chk("r9 osb[4]", osb[2][4], 64'd0);

    // Randomized blocks on every instance.
    for (int r = 0; r < 6; r++)
      run_block(r % ND, 1'($urandom), $urandom_range(0, 4), '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/sha3_state_loader.md
# sha3_state_loader

Assembles a 1600-bit Keccak state from a stream of 64-bit lanes and hands it, as a parallel 5×5 lane array with a one-cycle `sample` strobe, to the first round stage (`sha3_theta` input side). It sits between the message/padding front end and the permutation pipeline. A fill buffer plus an output register form a double buffer, so the front end can refill while the downstream stage holds the previous state.

## Interface
- `RATE_LANES`, 17 — lanes taken from the stream per block; legal range 1..25. Lanes at index ≥ RATE_LANES are forced to zero (capacity).
- `clk`  in  1 — single clock; all state updates on its rising edge.
- `rst`  in  1 — asynchronous, active-high reset.
- `lane_in`  in  64 — lane data.
- `lane_valid`  in  1 — `lane_in` is valid.
- `lane_ready`  out  1 — loader accepts a lane this cycle.
- `down_ready`  in  1 — downstream round stage can take a new state.
- `osa`, `osb`, `osc`, `osd`, `ose`  out  64 × [0:4] each — state rows y=0..4; `os<row>[x]` holds lane index 5·y+x.
- `sample`  out  1 — one-cycle strobe: `os*` carries a new state this cycle.
- `fill_count`  out  5 — lanes accepted into the current block, 0..RATE_LANES.

## Operation
- Lane index k maps to x = k mod 5, y = k div 5. Lanes arrive in ascending k, starting at 0.
- A lane is accepted on a rising edge when `lane_valid && lane_ready`. Accepting a lane writes the fill buffer at index `fill_count` and increments `fill_count`.
- FSM states:
  - FILL: `lane_ready` = 1. When the accepted lane is number RATE_LANES (`fill_count` == RATE_LANES−1 at the accepting edge), go to HOLD.
  - HOLD: `lane_ready` = 0; `lane_valid` is ignored. When `down_ready` = 1 at an edge, dispatch and go to FILL.
- Dispatch, on one edge:
  - Output register ← fill buffer, with capacity lanes zeroed.
  - `sample` ← 1.
  - Fill buffer ← all zero; `fill_count` ← 0.
- `sample` is registered. It is 1 for exactly the cycle after the dispatch edge and 0 otherwise.
- `os*` are driven straight from the output register. They change only at dispatch and hold their value until the next dispatch.
- `down_ready` is ignored in FILL. There is no early dispatch and no partial block.
- `lane_valid` gaps are allowed at any point in FILL. The FSM stays in FILL and no bubble lane is written.
- Reset, asynchronous, at any time including mid-fill or during HOLD:
  - state = FILL, `fill_count` = 0, fill buffer = 0, output register = 0, `sample` = 0.
  - `lane_ready` = 0 while `rst` is high. Partially loaded lanes are discarded.

## Timing
- Reset values: `os*` all 0, `sample` 0, `fill_count` 0, `lane_ready` 0 during reset and 1 from the first cycle after release.
- Last lane accepted at edge N:
  - Earliest dispatch is edge N+1 (HOLD, `down_ready` = 1).
  - `sample` and the new `os*` are visible in cycle N+1..N+2, i.e. after edge N+1.
- `lane_ready` rises again in the cycle after the dispatch edge, the same cycle `sample` is high.
- Peak throughput: one block per RATE_LANES+1 cycles.
- `lane_ready` is a pure function of FSM state and `rst`. It has no combinational path from `lane_valid` or `down_ready`.

## Structure
- Shared package `sha3_pkg`:
  - `lane_t` (64-bit logic).
  - `NUM_LANES` = 25.
  - Rate constants `RATE_224`=18, `RATE_256`=17, `RATE_384`=13, `RATE_512`=9.
  - Loader FSM enum `loader_state_t` {FILL, HOLD}.
- No sub-module. The fill buffer, output register and 2-state FSM are one flat block. An elaboration-time assertion rejects RATE_LANES outside 1..25.

## Test plan
- Reset check:
  - Stimulus: hold `rst` with random inputs, then release.
  - Required: all `os*` = 0, `sample` = 0, `fill_count` = 0, `lane_ready` = 0 during reset and 1 after release.
- Back-to-back fill, RATE_LANES=17:
  - Stimulus: `down_ready` = 1; lanes 0..16 with value k+1 on consecutive edges.
  - Required: `sample` = 1 for one cycle, two edges after the 17th accept.
  - Required: `osa` = {1,2,3,4,5}, `osb` = {6..10}, `osc` = {11..15}, `osd` = {16,17,0,0,0}, `ose` all 0.
- Backpressure:
  - Stimulus: the same stream, with `down_ready` = 0 for 10 cycles after the buffer fills.
  - Required: `lane_ready` = 0 and `sample` = 0 throughout; dispatch one edge after `down_ready` rises.
  - Required: a second block streamed immediately afterwards arrives intact while `os*` keeps block 1 unchanged until block 2 dispatches.
- Valid gaps:
  - Stimulus: `lane_valid` toggling 1,0,0,1… over 17 lanes.
  - Required: the same output as the back-to-back case; `fill_count` advances only on accepted lanes.
- Reset mid-fill:
  - Stimulus: assert `rst` after 8 lanes (value 0xDEAD), then stream 17 lanes of value k+0x100.
  - Required: the dispatched state contains no 0xDEAD; lane 0 = 0x100.
- RATE_LANES=25 and RATE_LANES=9:
  - Stimulus: fill with value k+1.
  - Required (25): `ose[4]` = 25.
  - Required (9): `osb[3]` = 9, `osb[4]` = 0, all lanes ≥ 9 are 0.
